// File: rtl/irda_tx_feeder.sv
// IrDA transmit feeder: byte FIFO plus a frame sequencer (issue, wait for done, inter-frame gap).
// Optional sticky overflow flag/port is built when IRDA_TX_FEEDER_OVERFLOW_EN is defined.
module irda_tx_feeder #(
   parameter int DEPTH          = 8,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   input  logic                     tx_done,
   output logic                     busy,
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
   output logic                     overflow,
`endif
   output logic                     tx_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP
   } state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          push;
   logic          pop;

   // A write into a full FIFO is dropped even if the sequencer pops in the same cycle.
   assign full     = (level == FULL_LEVEL);
   assign empty    = (level == '0);
   assign count    = level;
   assign push     = wr_en & ~full;
   assign pop      = ena & (state == IDLE) & ~empty;
   assign tx_start = ena & (state == ISSUE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Sequencer: everything holds while ena is low; tx_data only ever changes on a pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         tx_data    <= 8'h00;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         tx_timeout <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               to_cnt <= '0;
               state  <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end
               end else if (to_cnt == TO_LAST) begin
                  // Abandon the frame; the byte is not re-sent.
                  to_cnt     <= to_cnt + TW'(1);
                  tx_timeout <= 1'b1;
                  state      <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            GAP: begin
               if (gap_cnt <= GW'(1)) begin
                  gap_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (wr_en & full) begin
         overflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_irda_tx_feeder.sv
// Directed bench for irda_tx_feeder (DEPTH=8, GAP_CYCLES=16, TIMEOUT_CYCLES=100).
// Overflow checks are compiled in only when IRDA_TX_FEEDER_OVERFLOW_EN is defined.
module tb_irda_tx_feeder;

   localparam int DEPTH          = 8;
   localparam int GAP_CYCLES     = 16;
   localparam int TIMEOUT_CYCLES = 100;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       busy;
   logic       tx_timeout;
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
   logic       overflow;
`endif

   int total = 0;
   int bad   = 0;

   irda_tx_feeder #(
      .DEPTH(DEPTH),
      .GAP_CYCLES(GAP_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .full(full),
      .empty(empty),
      .count(count),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_done(tx_done),
      .busy(busy),
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
      .overflow(overflow),
`endif
      .tx_timeout(tx_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (tx_start !== 1'b1 && n < 60) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int extra;

      rst = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
      step();
      step();
      check_output("rst_empty", empty, 1);
      check_output("rst_full", full, 0);
      check_output("rst_count", count, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_tx_start", tx_start, 0);
      check_output("rst_tx_data", tx_data, 8'h00);
      check_output("rst_timeout", tx_timeout, 0);
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
      check_output("rst_overflow", overflow, 0);
`endif
      rst = 1'b1;
      step();

      $display("[TB] single byte latency and gap");
      wr_en = 1'b1; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      check_output("t1_visible_empty", empty, 0);
      check_output("t1_count", count, 1);
      check_output("t1_no_start_yet", tx_start, 0);
      step();
      check_output("t1_start", tx_start, 1);
      check_output("t1_data", tx_data, 8'hA5);
      check_output("t1_busy", busy, 1);
      check_output("t1_popped", empty, 1);
      step();
      check_output("t1_start_single", tx_start, 0);
      repeat (19) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (15) step();
      check_output("t1_gap_busy", busy, 1);
      step();
      check_output("t1_gap_end_idle", busy, 0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check_output("t1_stray_done", busy, 0);

      $display("[TB] burst fill, drop when full, ordered issue");
      ena = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      check_output("t2_full", full, 1);
      check_output("t2_count8", count, 8);
      wr_data = 8'hFF;
      step();
      wr_en = 1'b0;
      check_output("t2_drop_count", count, 8);
      check_output("t2_still_full", full, 1);
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
      check_output("t2_overflow", overflow, 1);
`endif
      ena = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wait_start(n);
         check_output("t2_start_seen", tx_start, 1);
         // tx_done cycle to tx_start cycle is GAP+2, i.e. GAP+1 edges after the done edge.
         if (i > 1) check_output("t2_spacing", n, GAP_CYCLES + 1);
         check_output("t2_order", tx_data, i);
         step();
         check_output("t2_single_pulse", tx_start, 0);
         step();
         step();
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
      end
      extra = 0;
      repeat (20) begin
         step();
         if (tx_start === 1'b1) extra++;
      end
      check_output("t2_no_ff_issued", extra, 0);
      check_output("t2_end_empty", empty, 1);
      check_output("t2_end_idle", busy, 0);
      check_output("t2_data_held", tx_data, 8'h08);
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
      check_output("t2_overflow_sticky", overflow, 1);
`endif

      $display("[TB] enable hold in ISSUE and WAIT_DONE");
      wr_en = 1'b1; wr_data = 8'h3C;
      step();
      wr_en = 1'b0;
      step();
      check_output("t3_issue", tx_start, 1);
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_output("t3_hold_start", tx_start, 0);
         check_output("t3_hold_busy", busy, 1);
         check_output("t3_hold_data", tx_data, 8'h3C);
      end
      ena = 1'b1;
      #1;
      check_output("t3_resume_start", tx_start, 1);
      step();
      check_output("t3_wait_start_low", tx_start, 0);
      ena = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (4) step();
      check_output("t3_hold_wait_busy", busy, 1);
      ena = 1'b1;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (15) step();
      check_output("t3_gap_busy", busy, 1);
      step();
      check_output("t3_gap_idle", busy, 0);

      $display("[TB] timeout in WAIT_DONE");
      ena = 1'b0;
      wr_en = 1'b1; wr_data = 8'h55;
      step();
      wr_data = 8'h66;
      step();
      wr_en = 1'b0;
      ena = 1'b1;
      step();
      check_output("t4_start", tx_start, 1);
      check_output("t4_data", tx_data, 8'h55);
      step();
      n = 0;
      while (tx_timeout !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check_output("t4_timeout_cycles", n, TIMEOUT_CYCLES);
      check_output("t4_timeout_idle", busy, 0);
      check_output("t4_data_retained", tx_data, 8'h55);
      step();
      check_output("t4_next_start", tx_start, 1);
      check_output("t4_next_data", tx_data, 8'h66);
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (16) step();
      check_output("t4_done_idle", busy, 0);
      check_output("t4_timeout_sticky", tx_timeout, 1);

      $display("[TB] reset mid-gap");
      wr_en = 1'b1; wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      step();
      step();
      wr_en = 1'b1; wr_data = 8'h11;
      step();
      wr_data = 8'h22;
      step();
      wr_data = 8'h33;
      step();
      wr_en = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      step();
      check_output("t5_pre_count", count, 3);
      check_output("t5_pre_busy", busy, 1);
      rst = 1'b0;
      step();
      check_output("t5_count", count, 0);
      check_output("t5_empty", empty, 1);
      check_output("t5_data", tx_data, 8'h00);
      check_output("t5_busy", busy, 0);
      check_output("t5_start", tx_start, 0);
      check_output("t5_timeout_clr", tx_timeout, 0);
`ifdef IRDA_TX_FEEDER_OVERFLOW_EN
      check_output("t5_overflow_clr", overflow, 0);
`endif
      rst = 1'b1;
      step();
      step();
      check_output("t5_after_busy", busy, 0);
      check_output("t5_after_count", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
